imm_encoder: RTL and testbench
==============================

# imm_encoder

Iterative immediate encoder: takes a 32-bit value and finds the instruction immediate field that the decode-side sign/zero-extension logic expands back to that same value. It sits on the assembler/patch path. It accepts one request at a time and searches the ARM rotated-8-bit form one rotation per cycle. It reports whether the value is encodable and, if so, the packed field plus U (up) bit.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request strobe; accepted only in IDLE.
- `value`  in  32  value to encode; captured on accept.
- `imme_sel`  in  2  form: 00 rotated imm8, 01 12-bit offset, 10 24-bit branch offset, 11 split 8-bit (halfword).
- `unsigned_en`  in  1  0 = treat `value` as signed; 1 = unsigned. Captured on accept.
- `busy`  out  1  high in SEARCH and DONE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `fits`  out  1  value is encodable in the selected form.
- `field`  out  24  packed immediate field, zero-extended to 24 bits.
- `up`  out  1  U bit for forms 01/11; 0 for other forms.

## Operation
- FSM states: IDLE -> SEARCH -> DONE -> IDLE.
- IDLE: when `start`=1, register `value`, `imme_sel` and `unsigned_en`, clear rotation counter `r`, go to SEARCH. `start` is ignored in SEARCH and DONE, with no queuing.
- Form 00, SEARCH: each cycle compute `t = value ROL (2*r)`.
  - If `t[31:8]==0`: match. Latch `field={12'b0, r[3:0], t[7:0]}` and `fits=1`, go to DONE. The smallest `r` wins.
  - Else if `r==15`: latch `fits=0`, `field=0`, go to DONE.
  - Else `r<=r+1`.
- Forms 01/10/11 are evaluated in a single SEARCH cycle, then go to DONE.
- Form 01:
  - Signed: `up = ~value[31]`, `mag = up ? value : -value` (32-bit); fits iff `mag < 4096`; `field={12'b0, mag[11:0]}`.
  - Unsigned: `up=1`, `mag=value`, same test.
- Form 11: same magnitude/up rules as form 01; fits iff `mag < 256`; `field={12'b0, mag[7:4], 4'b0000, mag[3:0]}`.
- Form 10: requires `value[1:0]==0`.
  - Signed: `value[31:25]` must all equal `value[25]`.
  - Unsigned: `value[31:26]` must be 0.
  - `field=value[25:2]`; `up=0`.
- Magnitude edge case: `value=0x80000000` signed gives `mag=0x80000000`, so fits=0.
- Whenever fits=0: `field=0` and `up=0`.
- DONE: `done=1` for exactly one cycle, then IDLE. `fits`/`field`/`up` hold until the next accept, then clear to 0 on the accept edge.

## Timing
- Reset: with `reset_n=0` at an edge, state becomes IDLE and `r=0`. All outputs (`busy`, `done`, `fits`, `field`, `up`) go to 0. Captured registers are cleared.
- Reset mid-SEARCH or in DONE aborts the request. No `done` is issued.
- Call the accept edge T.
  - `busy` is high from T+1.
  - Forms 01/10/11: `done` is high in cycle T+2.
  - Form 00, match at rotation r: `done` is high in cycle T+2+r.
  - Form 00, no match: `done` is high in cycle T+17. Worst case is 17 cycles.
- `busy` falls in the cycle after `done`.
- A new `start` in that first IDLE cycle is accepted, so back-to-back throughput is one request per (latency+1) cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Form 00, `value=0x000000FF` -> done at T+2, fits=1, field=0x0000FF.
- Form 00, `value=0xFF000000` -> done at T+6, fits=1, field=0x0004FF (r=4).
- Form 00, `value=0x00000101` -> done at T+17, fits=0, field=0.
- Form 01, signed, `value=0xFFFFFFFC` (-4) -> fits=1, up=0, field=0x000004.
- Form 01, unsigned, `value=0x00001000` -> fits=0.
- Form 11, signed, `value=0x000000A5` -> fits=1, up=1, field=0x000A05.
- Form 10, signed, `value=0xFFFFFFF8` -> fits=1, field=0xFFFFFE.
- Form 10, `value=0x00000006` (unaligned) -> fits=0.
- Reset and busy handling, form 00 with `value=0x00000101`:
  - Assert `start` again at T+3 -> ignored.
  - Assert `reset_n=0` at T+5 -> no `done`; all outputs 0 at T+6.
  - New request accepted afterwards and completes normally.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: iterative immediate encoder for the assembler/patch path.
// Finds the instruction immediate field that decode-side extension expands
// back to the requested 32-bit value. The rotated imm8 form is searched one
// rotation per cycle; the offset, branch and split-halfword forms resolve
// in a single search cycle. All outputs are registered.

module imm_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [1:0]  imme_sel,
    input  logic        unsigned_en,
    output logic        busy,
    output logic        done,
    output logic        fits,
    output logic [23:0] field,
    output logic        up
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        F_ROT8   = 2'b00,
        F_OFF12  = 2'b01,
        F_BR24   = 2'b10,
        F_SPLIT8 = 2'b11
    } form_t;

    state_t      state, state_n;

    // Request captured on accept
    logic [31:0] val_q, val_n;
    form_t       sel_q, sel_n;
    logic        uns_q, uns_n;
    logic [3:0]  r_q, r_n;

    // Next values of the registered outputs
    logic        busy_n, done_n, fits_n, up_n;
    logic [23:0] field_n;

    // Form evaluation results
    logic [31:0] rot;
    logic        rot_hit;
    logic        mag_up;
    logic [31:0] mag;
    logic        off12_fits;
    logic        split8_fits;
    logic        br_aligned;
    logic        br_range;
    logic        br_fits;

    // Left rotate by an even amount; with sh==0 the right shift amount wraps
    // to 0 as well, so the OR simply returns v.
    function automatic logic [31:0] rol_even(input logic [31:0] v, input logic [3:0] r);
        logic [4:0] sh;
        sh = {r, 1'b0};
        return (v << sh) | (v >> (~sh + 5'd1));
    endfunction

    // Rotated-imm8 candidate for the current rotation step
    always_comb begin
        rot     = rol_even(val_q, r_q);
        rot_hit = (rot[31:8] == 24'd0);
    end

    // Magnitude and direction for the offset and split-halfword forms
    always_comb begin
        mag_up      = uns_q | ~val_q[31];
        mag         = mag_up ? val_q : (~val_q + 32'd1);
        off12_fits  = (mag[31:12] == 20'd0);
        split8_fits = (mag[31:8] == 24'd0);
    end

    // Branch offset: word aligned and within the 26-bit byte range
    always_comb begin
        br_aligned = (val_q[1:0] == 2'b00);
        if (uns_q) begin
            br_range = (val_q[31:26] == 6'd0);
        end else begin
            br_range = (val_q[31:25] == '0) || (val_q[31:25] == '1);
        end
        br_fits = br_aligned && br_range;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, capture and result selection
    always_comb begin
        state_n = state;
        val_n   = val_q;
        sel_n   = sel_q;
        uns_n   = uns_q;
        r_n     = r_q;
        busy_n  = busy;
        done_n  = 1'b0;
        fits_n  = fits;
        field_n = field;
        up_n    = up;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    val_n   = value;
                    sel_n   = form_t'(imme_sel);
                    uns_n   = unsigned_en;
                    r_n     = 4'd0;
                    busy_n  = 1'b1;
                    fits_n  = 1'b0;
                    field_n = '0;
                    up_n    = 1'b0;
                    state_n = S_SEARCH;
                end
            end

            S_SEARCH: begin
                unique case (sel_q)
                    F_ROT8: begin
                        if (rot_hit) begin
                            fits_n  = 1'b1;
                            field_n = {12'd0, r_q, rot[7:0]};
                            up_n    = 1'b0;
                            done_n  = 1'b1;
                            state_n = S_DONE;
                        end else if (r_q == 4'd15) begin
                            fits_n  = 1'b0;
                            field_n = '0;
                            up_n    = 1'b0;
                            done_n  = 1'b1;
                            state_n = S_DONE;
                        end else begin
                            r_n = r_q + 4'd1;
                        end
                    end

                    F_OFF12: begin
                        fits_n  = off12_fits;
                        field_n = off12_fits ? {12'd0, mag[11:0]} : '0;
                        up_n    = off12_fits & mag_up;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end

                    F_BR24: begin
                        fits_n  = br_fits;
                        field_n = br_fits ? val_q[25:2] : '0;
                        up_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end

                    F_SPLIT8: begin
                        fits_n  = split8_fits;
                        field_n = split8_fits ? {12'd0, mag[7:4], 4'b0000, mag[3:0]} : '0;
                        up_n    = split8_fits & mag_up;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end

                    default: begin
                        state_n = S_IDLE;
                    end
                endcase
            end

            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Captured request, rotation counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val_q <= '0;
            sel_q <= F_ROT8;
            uns_q <= 1'b0;
            r_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            fits  <= 1'b0;
            field <= '0;
            up    <= 1'b0;
        end else begin
            val_q <= val_n;
            sel_q <= sel_n;
            uns_q <= uns_n;
            r_q   <= r_n;
            busy  <= busy_n;
            done  <= done_n;
            fits  <= fits_n;
            field <= field_n;
            up    <= up_n;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors with hand-computed results.
// The driver pushes expected results into a queue at accept time; a
// monitor pops and compares whenever done is seen.

module tb_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] value;
    logic [1:0]  imme_sel;
    logic        unsigned_en;
    logic        busy;
    logic        done;
    logic        fits;
    logic [23:0] field;
    logic        up;

    imm_encoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .value       (value),
        .imme_sel    (imme_sel),
        .unsigned_en (unsigned_en),
        .busy        (busy),
        .done        (done),
        .fits        (fits),
        .field       (field),
        .up          (up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] v;
        logic [1:0]  sel;
        logic        uns;
        logic        f;
        logic [23:0] fld;
        logic        u;
        int          lat;
    } vec_t;

    typedef struct {
        logic        f;
        logic [23:0] fld;
        logic        u;
        int          lat;
        int          t0;
        int          id;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: compare each done pulse against the oldest expectation
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) begin
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse_width: done=%b required 0", done);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done at cycle %0d: fits=%b field=%06h up=%b", cyc, fits, field, up);
            end else begin
                exp_t e;
                int lat_got;
                e = exp_q.pop_front();
                lat_got = cyc - e.t0 + 1;
                if (fits !== e.f || field !== e.fld || up !== e.u || lat_got != e.lat) begin
                    failures++;
                    $display("FAIL result_vec%0d: fits=%b field=%06h up=%b lat=%0d required fits=%b field=%06h up=%b lat=%0d",
                             e.id, fits, field, up, lat_got, e.f, e.fld, e.u, e.lat);
                end
            end
        end
        prev_done = (done === 1'b1);
    end

    vec_t vecs[$];

    // Issue a request at a negedge, check acceptance, wait for completion,
    // then check the results hold in the first idle cycle.
    task automatic run_vec(input vec_t v, input int id);
        exp_t e;
        int n;
        value       = v.v;
        imme_sel    = v.sel;
        unsigned_en = v.uns;
        start       = 1'b1;
        e.f = v.f; e.fld = v.fld; e.u = v.u; e.lat = v.lat; e.t0 = cyc + 1; e.id = id;
        exp_q.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        value       = ~v.v;
        imme_sel    = v.sel ^ 2'b11;
        unsigned_en = ~v.uns;
        checks++;
        if (busy !== 1'b1 || fits !== 1'b0 || field !== 24'd0 || up !== 1'b0) begin
            failures++;
            $display("FAIL accept_vec%0d: busy=%b fits=%b field=%06h up=%b required busy=1 fits=0 field=000000 up=0",
                     id, busy, fits, field, up);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL timeout_vec%0d: busy still %b after %0d cycles, required 0", id, busy, n);
        end
        checks++;
        if (fits !== v.f || field !== v.fld || up !== v.u) begin
            failures++;
            $display("FAIL hold_vec%0d: fits=%b field=%06h up=%b required fits=%b field=%06h up=%b",
                     id, fits, field, up, v.f, v.fld, v.u);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] v, input logic [1:0] sel, input logic uns,
                                input logic f, input logic [23:0] fld, input logic u, input int lat);
        vec_t x;
        x.v = v; x.sel = sel; x.uns = uns; x.f = f; x.fld = fld; x.u = u; x.lat = lat;
        return x;
    endfunction

    initial begin
        int t;
        // Form 00 rotated imm8
        vecs.push_back(mk(32'h000000FF, 2'b00, 1'b0, 1'b1, 24'h0000FF, 1'b0, 2));
        vecs.push_back(mk(32'hFF000000, 2'b00, 1'b0, 1'b1, 24'h0004FF, 1'b0, 6));
        vecs.push_back(mk(32'h00000101, 2'b00, 1'b0, 1'b0, 24'h000000, 1'b0, 17));
        vecs.push_back(mk(32'h000003FC, 2'b00, 1'b0, 1'b1, 24'h000FFF, 1'b0, 17));
        vecs.push_back(mk(32'hF000000F, 2'b00, 1'b0, 1'b1, 24'h0002FF, 1'b0, 4));
        vecs.push_back(mk(32'h00000000, 2'b00, 1'b1, 1'b1, 24'h000000, 1'b0, 2));
        // Form 01 12-bit offset
        vecs.push_back(mk(32'hFFFFFFFC, 2'b01, 1'b0, 1'b1, 24'h000004, 1'b0, 2));
        vecs.push_back(mk(32'h00001000, 2'b01, 1'b1, 1'b0, 24'h000000, 1'b0, 2));
        vecs.push_back(mk(32'h00000FFF, 2'b01, 1'b1, 1'b1, 24'h000FFF, 1'b1, 2));
        vecs.push_back(mk(32'hFFFFF001, 2'b01, 1'b0, 1'b1, 24'h000FFF, 1'b0, 2));
        vecs.push_back(mk(32'h80000000, 2'b01, 1'b0, 1'b0, 24'h000000, 1'b0, 2));
        vecs.push_back(mk(32'h00000123, 2'b01, 1'b0, 1'b1, 24'h000123, 1'b1, 2));
        // Form 11 split 8-bit
        vecs.push_back(mk(32'h000000A5, 2'b11, 1'b0, 1'b1, 24'h000A05, 1'b1, 2));
        vecs.push_back(mk(32'hFFFFFF00, 2'b11, 1'b0, 1'b0, 24'h000000, 1'b0, 2));
        vecs.push_back(mk(32'h000000FF, 2'b11, 1'b1, 1'b1, 24'h000F0F, 1'b1, 2));
        // Form 10 branch offset
        vecs.push_back(mk(32'hFFFFFFF8, 2'b10, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 2));
        vecs.push_back(mk(32'h00000006, 2'b10, 1'b0, 1'b0, 24'h000000, 1'b0, 2));
        vecs.push_back(mk(32'h03FFFFFC, 2'b10, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 2));
        vecs.push_back(mk(32'h02000000, 2'b10, 1'b0, 1'b0, 24'h000000, 1'b0, 2));
        vecs.push_back(mk(32'h02000000, 2'b10, 1'b1, 1'b1, 24'h800000, 1'b0, 2));

        reset_n     = 1'b0;
        start       = 1'b0;
        value       = '0;
        imme_sel    = '0;
        unsigned_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fits !== 1'b0 || field !== 24'd0 || up !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b fits=%b field=%06h up=%b required all 0",
                     busy, done, fits, field, up);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Ignored start while busy, then reset mid-search aborts the request
        value       = 32'h00000101;
        imme_sel    = 2'b00;
        unsigned_en = 1'b0;
        start       = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        value       = 32'h000000FF;
        imme_sel    = 2'b01;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (cyc != t + 5 || busy !== 1'b0 || done !== 1'b0 || fits !== 1'b0 || field !== 24'd0 || up !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: cycle_off=%0d busy=%b done=%b fits=%b field=%06h up=%b required cycle_off=5 all 0",
                     cyc - t, busy, done, fits, field, up);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_abort: busy=%b required 0", busy);
        end

        // Fresh request after the abort completes normally
        run_vec(mk(32'hFF000000, 2'b00, 1'b0, 1'b1, 24'h0004FF, 1'b0, 6), 100);
        run_vec(mk(32'hFFFFFFFC, 2'b11, 1'b0, 1'b1, 24'h000004, 1'b0, 2), 101);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_done: %0d expected results never seen, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
